spi_slave_multi: RTL and testbench
==================================

Name: spi_slave_multi

Overview:
Parametrised SPI slave and successor to spi_slave_2. Supports configurable word width, all four SPI modes selected at run time, and MSB- or LSB-first order. Handles multi-word frames under one spi_cs assertion, with a one-entry TX holding buffer using a valid/ready handshake. Sits between an external SPI master and the on-chip register/command logic, all in the clk domain.

Parameters:
DATA_W, 8, word width in bits (2..32)
LSB_FIRST, 0, 0 = MSB first on both mosi and miso; 1 = LSB first
SYNC_STAGES, 2, synchroniser flops on spi_cs, spi_sck and spi_mosi (minimum 2)
TX_FILL, {DATA_W{1'b1}}, word shifted out when the TX buffer is empty at a load point

Ports:
clk  in  1  system clock
rst  in  1  reset
spi_cs  in  1  chip select, active low
spi_sck  in  1  SPI clock from the master
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  miso output enable, high while the frame is active
cfg_cpol  in  1  clock polarity; sampled only in IDLE
cfg_cpha  in  1  clock phase; sampled only in IDLE
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  TX holding buffer is empty
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-cycle pulse: rx_data updated
tx_underrun  out  1  one-cycle pulse: TX_FILL was loaded
frame_err  out  1  one-cycle pulse: cs rose mid-word
spi_over  out  1  one-cycle pulse at end of every active frame
busy  out  1  high while in ACTIVE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0, spi_over=0, busy=0, FSM=IDLE, bit_cnt=0, TX buffer empty.
- Synchronisation:
  - spi_cs, spi_sck and spi_mosi each pass through SYNC_STAGES flops. Edges are detected on the synced signals.
  - Requirement: sck high time and low time are each ≥ SYNC_STAGES+2 clk periods.
- Edge roles:
  - Leading edge is rising when cpol=0, falling when cpol=1; trailing edge is the opposite.
  - cpha=0: sample on leading, shift on trailing.
  - cpha=1: shift on leading, sample on trailing.
- FSM:
  - IDLE -> ACTIVE on a synced cs fall. In that same cycle: latch cpol/cpha, set bit_cnt=0, load the TX shift register, set spi_miso_oe=1. With cpha=0, spi_miso takes the first bit in that same cycle.
  - ACTIVE -> IDLE on a synced cs rise: spi_over=1 for one cycle, spi_miso_oe=0, busy=0.
  - If bit_cnt≠0 at that cs rise: frame_err=1 for one cycle, the partial word is discarded, rx_valid stays 0.
- Shift/sample:
  - Each sample edge shifts mosi into the RX shift register and increments bit_cnt.
  - When bit_cnt reaches DATA_W: bit_cnt wraps to 0. rx_data takes the full word and rx_valid=1 on the following clk. The TX shift register reloads immediately.
  - With cpha=1, the reloaded word's first bit goes out on the next leading edge.
- TX buffer:
  - A write occurs when tx_valid && tx_ready; after the write, tx_ready=0.
  - Load points are frame start and each word wrap. At a load point, the buffer content moves to the shift register and tx_ready=1 on the next cycle.
  - If the buffer is empty at a load point: load TX_FILL and pulse tx_underrun.
  - A write and a load in the same cycle cannot collide: tx_ready=0 means the buffer is full; tx_ready=1 means the buffer is empty, so the load sees it empty and the write is accepted.
- Bit order: LSB_FIRST selects both the shift direction and the final rx_data alignment. rx_data always holds bit0 = LSB of the word.
- cfg_cpol and cfg_cpha changes during ACTIVE are ignored.
- Reset mid-frame:
  - Immediate return to IDLE and all outputs to reset values; no spi_over pulse.
  - If synced cs is low when reset releases, the block waits for cs to go high before it can enter ACTIVE again.
- Simultaneous cs rise and sample edge: the cs rise has priority and the edge is ignored.

Test Plan:
- Mode 0, DATA_W=8, tx buffer pre-loaded 0xA5, master sends 0x81 -> rx_data=0x81 with one rx_valid pulse; miso bits 1,0,1,0,0,1,0,1; spi_over pulses once after cs rises.
- Mode 3, two words (0x04 then 0x01) in one frame, tx 0x3C written while the first word shifts -> two rx_valid pulses (0x04, 0x01); second miso word 0x3C; tx_ready returns to 1 after each load.
- Empty TX buffer, mode 1, master sends 0x00 -> miso all 1s (TX_FILL), tx_underrun pulses once at frame start; rx_data=0x00.
- cs raised after 3 sck edges, mode 0 -> frame_err and spi_over pulse once each; no rx_valid; rx_data keeps its previous value.
- LSB_FIRST=1, DATA_W=16, master sends 0x1234 LSB first, tx 0xBEEF -> rx_data=0x1234; miso order starts with 1,1,1,1,0,1,1,1.
- rst asserted after 4 bits with cs held low, then released -> outputs at reset values; no rx_valid on the remaining edges; next frame, after cs goes high then low, receives 0x55 correctly.

Source files
------------

// File: rtl/spi_slave_multi.sv
// -----------------------------------------------------------------------------
// spi_slave_multi
//   SPI slave with run-time selectable mode (cpol/cpha), configurable word
//   width and bit order, and multi-word frames under a single chip select.
//   A one-entry TX holding buffer (valid/ready) feeds the transmit shift
//   register at every load point (frame start and every word wrap).
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   spi_cs/sck/mosi          raw SPI inputs from the master (asynchronous)
//   spi_miso, spi_miso_oe    slave data out and its output enable
//   cfg_cpol, cfg_cpha       SPI mode, captured at frame start only
//   tx_data/valid/ready      TX holding buffer write handshake
//   rx_data, rx_valid        last complete received word + one-cycle strobe
//   tx_underrun              pulse: TX_FILL loaded because the buffer was empty
//   frame_err                pulse: cs rose with a partial word in flight
//   spi_over                 pulse: end of an active frame
//   busy                     high while a frame is active
// -----------------------------------------------------------------------------
module spi_slave_multi #(
    parameter int                DATA_W      = 8,
    parameter bit                LSB_FIRST   = 1'b0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_FILL     = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              spi_over,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: index 0 = cs, 1 = sck, 2 = mosi.
    // Cleared to 0 by reset so that a cs held low across reset never looks
    // like a falling edge; cs must be seen high before a frame can start.
    // ------------------------------------------------------------------
    logic [2:0] pin_raw;
    logic [2:0] pin_s;

    assign pin_raw = {spi_mosi, spi_sck, spi_cs};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw[gi]};
            end
        end
        assign pin_s[gi] = sync_q[SYNC_STAGES-1];
    end

    logic cs_s, sck_s, mosi_s;
    assign cs_s   = pin_s[0];
    assign sck_s  = pin_s[1];
    assign mosi_s = pin_s[2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                cs_prev_q, sck_prev_q;
    logic                cpol_q, cpol_d, cpha_q, cpha_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                underrun_q, underrun_d;
    logic                frame_err_q, frame_err_d;
    logic                spi_over_q, spi_over_d;
    logic                miso_q, miso_d;
    logic                miso_oe_q, miso_oe_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;

    // Edge decode on the synchronised signals
    logic cs_fall, cs_rise, sck_rise, sck_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic load;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] rx_next;

    assign cs_fall    = cs_prev_q & ~cs_s;
    assign cs_rise    = ~cs_prev_q & cs_s;
    assign sck_rise   = ~sck_prev_q & sck_s;
    assign sck_fall   = sck_prev_q & ~sck_s;
    assign lead_edge  = cpol_q ? sck_fall : sck_rise;
    assign trail_edge = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    // Word handed to the shift register at a load point
    assign load_word = buf_full_q ? buf_q : TX_FILL;

    // RX shift direction leaves the word LSB-aligned after DATA_W bits
    assign rx_next = LSB_FIRST ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                               : {rx_shift_q[DATA_W-2:0], mosi_s};

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic. tx_shift holds the bits not yet driven onto miso;
    // each shift edge moves the next one into miso_q.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        spi_over_d  = 1'b0;
        miso_d      = miso_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        load        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    cpol_d    = cfg_cpol;
                    cpha_d    = cfg_cpha;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                    if (!cfg_cpha) begin
                        // cpha=0: first bit must be on miso before the first edge
                        miso_d     = first_bit(load_word);
                        tx_shift_d = drop_bit(load_word);
                    end else begin
                        tx_shift_d = load_word;
                    end
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    // cs rise wins over any coincident sck edge
                    state_d     = ST_IDLE;
                    spi_over_d  = 1'b1;
                    frame_err_d = (bit_cnt_q != '0);
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            load       = 1'b1;
                            // Full word: its first bit leaves on the next shift edge
                            tx_shift_d = load_word;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        miso_d     = first_bit(tx_shift_q);
                        tx_shift_d = drop_bit(tx_shift_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Buffer: load consumes, write fills. A write can only be accepted
        // when the buffer is empty, so a coincident load sees it empty.
        if (load) begin
            if (buf_full_q) begin
                buf_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        miso_oe_d = (state_d == ST_ACTIVE);
        busy_d    = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            spi_over_q  <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
            spi_over_q  <= spi_over_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign frame_err   = frame_err_q;
    assign spi_over    = spi_over_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_multi.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_multi
//   Drives two instances (8-bit MSB-first, 16-bit LSB-first) from a behavioural
//   SPI master. Expected miso words, rx words and pulse counts come from a
//   frame-level model: the sequence of words loaded at each load point.
// -----------------------------------------------------------------------------
module tb_spi_slave_multi;

    localparam int HALF = 8;   // sck half period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cs, sck, mosi, cpol, cpha, txv;
    logic [31:0] txw;
    logic        sel;            // 0 = 8-bit instance, 1 = 16-bit instance

    logic cs8, cs16, txv8, txv16;
    assign cs8   = sel ? 1'b1 : cs;
    assign cs16  = sel ? cs : 1'b1;
    assign txv8  = sel ? 1'b0 : txv;
    assign txv16 = sel ? txv : 1'b0;

    logic        miso8, oe8, rdy8, rxv8, und8, fe8, ov8, busy8;
    logic [7:0]  rx8;
    logic        miso16, oe16, rdy16, rxv16, und16, fe16, ov16, busy16;
    logic [15:0] rx16;

    spi_slave_multi #(.DATA_W(8), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .spi_cs(cs8), .spi_sck(sck), .spi_mosi(mosi),
        .spi_miso(miso8), .spi_miso_oe(oe8), .cfg_cpol(cpol), .cfg_cpha(cpha),
        .tx_data(txw[7:0]), .tx_valid(txv8), .tx_ready(rdy8), .rx_data(rx8),
        .rx_valid(rxv8), .tx_underrun(und8), .frame_err(fe8), .spi_over(ov8),
        .busy(busy8)
    );

    spi_slave_multi #(.DATA_W(16), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) u_dut16 (
        .clk(clk), .rst(rst), .spi_cs(cs16), .spi_sck(sck), .spi_mosi(mosi),
        .spi_miso(miso16), .spi_miso_oe(oe16), .cfg_cpol(cpol), .cfg_cpha(cpha),
        .tx_data(txw[15:0]), .tx_valid(txv16), .tx_ready(rdy16), .rx_data(rx16),
        .rx_valid(rxv16), .tx_underrun(und16), .frame_err(fe16), .spi_over(ov16),
        .busy(busy16)
    );

    logic        m_miso, m_oe, m_rdy, m_rxv, m_und, m_fe, m_ov, m_busy;
    logic [31:0] m_rx;
    assign m_miso = sel ? miso16 : miso8;
    assign m_oe   = sel ? oe16   : oe8;
    assign m_rdy  = sel ? rdy16  : rdy8;
    assign m_rxv  = sel ? rxv16  : rxv8;
    assign m_und  = sel ? und16  : und8;
    assign m_fe   = sel ? fe16   : fe8;
    assign m_ov   = sel ? ov16   : ov8;
    assign m_busy = sel ? busy16 : busy8;
    assign m_rx   = sel ? {16'h0, rx16} : {24'h0, rx8};

    // Pulse monitors
    int          n_rxv = 0, n_und = 0, n_fe = 0, n_ov = 0;
    logic [31:0] rx_q[$];
    always @(negedge clk) begin
        if (m_rxv) begin
            n_rxv++;
            rx_q.push_back(m_rx);
        end
        if (m_und) n_und++;
        if (m_fe)  n_fe++;
        if (m_ov)  n_ov++;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    endfunction

    function automatic logic getbit(input logic [31:0] wd, input int w, input bit lsb, input int pos);
        int idx;
        idx = lsb ? pos : (w - 1 - pos);
        return wd[idx];
    endfunction

    // Per-frame stimulus: master words and optional mid-word TX writes
    logic [31:0] fr_mosi [4];
    bit          fr_wr   [4];
    logic [31:0] fr_wrw  [4];

    task automatic clear_fr();
        for (int k = 0; k < 4; k++) begin
            fr_mosi[k] = '0;
            fr_wr[k]   = 1'b0;
            fr_wrw[k]  = '0;
        end
    endtask

    task automatic tx_write(input string tag, input logic [31:0] val);
        check({tag, "_rdy"}, {31'h0, m_rdy}, 32'h1);
        txw = val;
        txv = 1'b1;
        @(negedge clk);
        txv = 1'b0;
        @(negedge clk);
        check({tag, "_full"}, {31'h0, m_rdy}, 32'h0);
    endtask

    // One SPI frame. abort_edges>0 raises cs after that many sck edges;
    // hold_low leaves cs asserted and skips the end-of-frame checks.
    task automatic spi_frame(input string name, input int w, input bit lsb,
                             input bit cp, input bit ch, input int nw,
                             input bit pre, input logic [31:0] prew,
                             input int abort_edges, input bit hold_low);
        logic [31:0] loads [5];
        logic        mb [128];
        logic [31:0] got, rx_before;
        int          exp_und, total_edges, rxv0, und0, fe0, ov0, bi;
        bit          abort;

        abort = (abort_edges > 0);
        // Model: word loaded at each load point, FILL when nothing was written
        loads[0] = pre ? (prew & wmask(w)) : wmask(w);
        exp_und  = pre ? 0 : 1;
        for (int k = 0; k < 4; k++)
            loads[k+1] = fr_wr[k] ? (fr_wrw[k] & wmask(w)) : wmask(w);
        if (!abort)
            for (int k = 0; k < nw; k++)
                if (!fr_wr[k]) exp_und++;
        for (int k = 0; k < 128; k++) mb[k] = 1'b0;

        cpol = cp;
        cpha = ch;
        sck  = cp;
        cs   = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        if (pre) tx_write({name, "_pre"}, prew & wmask(w));
        rxv0 = n_rxv; und0 = n_und; fe0 = n_fe; ov0 = n_ov;
        rx_before = m_rx;

        if (!ch) mosi = getbit(fr_mosi[0], w, lsb, 0);
        cs = 1'b0;
        total_edges = abort ? abort_edges : 2 * nw * w;
        for (int e = 0; e < total_edges; e++) begin
            bi = e / 2;
            repeat (HALF) @(negedge clk);
            if ((e % 2) == 0) begin
                if (!ch) mb[bi] = m_miso;
                sck = ~cp;
                if (ch) mosi = getbit(fr_mosi[bi / w], w, lsb, bi % w);
                if (!abort && (bi % w) == w / 2 && fr_wr[bi / w])
                    tx_write({name, "_mid"}, fr_wrw[bi / w] & wmask(w));
            end else begin
                if (ch) mb[bi] = m_miso;
                sck = cp;
                if (!ch && (bi + 1) < nw * w)
                    mosi = getbit(fr_mosi[(bi + 1) / w], w, lsb, (bi + 1) % w);
            end
            // Mode changes while active must have no effect
            if (e == 0) begin
                cpol = ~cp;
                cpha = ~ch;
            end
        end
        repeat (HALF) @(negedge clk);
        if (hold_low) return;
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);

        check({name, "_over"}, n_ov - ov0, 32'd1);
        check({name, "_busy"}, {31'h0, m_busy}, 32'h0);
        check({name, "_oe"},   {31'h0, m_oe}, 32'h0);
        if (abort) begin
            check({name, "_ferr"}, n_fe - fe0, 32'd1);
            check({name, "_rxv"},  n_rxv - rxv0, 32'd0);
            check({name, "_rxkeep"}, m_rx, rx_before);
            check({name, "_und"},  n_und - und0, exp_und);
        end else begin
            check({name, "_ferr"}, n_fe - fe0, 32'd0);
            check({name, "_rxv"},  n_rxv - rxv0, nw);
            check({name, "_und"},  n_und - und0, exp_und);
            check({name, "_rdy"},  {31'h0, m_rdy}, 32'h1);
            for (int j = 0; j < nw; j++) begin
                if (rx_q.size() > rxv0 + j)
                    check({name, "_rx"}, rx_q[rxv0 + j], fr_mosi[j] & wmask(w));
                got = '0;
                for (int p = 0; p < w; p++)
                    got[lsb ? p : (w - 1 - p)] = mb[j * w + p];
                check({name, "_miso"}, got, loads[j]);
            end
        end
    endtask

    initial begin
        int nw;
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; txv = 1'b0; txw = '0; sel = 1'b0;
        clear_fr();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * HALF) @(negedge clk);

        // Reset state of both instances
        check("rst_miso", {31'h0, miso8}, 32'h0);
        check("rst_oe",   {31'h0, oe8}, 32'h0);
        check("rst_rdy",  {31'h0, rdy8}, 32'h1);
        check("rst_rx",   {24'h0, rx8}, 32'h0);
        check("rst_busy", {31'h0, busy8}, 32'h0);
        check("rst_pulses", {28'h0, rxv8, und8, fe8, ov8}, 32'h0);
        check("rst_rdy16", {31'h0, rdy16}, 32'h1);
        check("rst_rx16",  {16'h0, rx16}, 32'h0);

        // Mode 0, preload A5, master sends 81
        clear_fr();
        fr_mosi[0] = 32'h81;
        spi_frame("m0", 8, 1'b0, 1'b0, 1'b0, 1, 1'b1, 32'hA5, 0, 1'b0);

        // Abort after 3 edges, mode 0: rx_data keeps 81
        clear_fr();
        fr_mosi[0] = 32'hFF;
        spi_frame("abort", 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h0, 3, 1'b0);

        // Mode 3, two words, 3C written during the first word
        clear_fr();
        fr_mosi[0] = 32'h04; fr_mosi[1] = 32'h01;
        fr_wr[0] = 1'b1; fr_wrw[0] = 32'h3C;
        spi_frame("m3", 8, 1'b0, 1'b1, 1'b1, 2, 1'b0, 32'h0, 0, 1'b0);

        // Mode 1, empty buffer at start -> FILL on miso; wrap load supplied
        clear_fr();
        fr_mosi[0] = 32'h00;
        fr_wr[0] = 1'b1; fr_wrw[0] = $urandom_range(0, 255);
        spi_frame("m1fill", 8, 1'b0, 1'b0, 1'b1, 1, 1'b0, 32'h0, 0, 1'b0);

        // 16-bit LSB-first instance
        sel = 1'b1;
        clear_fr();
        fr_mosi[0] = 32'h1234;
        spi_frame("lsb16", 16, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'hBEEF, 0, 1'b0);
        sel = 1'b0;

        // Reset after 4 bits with cs held low
        clear_fr();
        fr_mosi[0] = 32'hC3;
        spi_frame("rstmid", 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h0, 8, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", {31'h0, busy8}, 32'h0);
        check("rstmid_oe",   {31'h0, oe8}, 32'h0);
        check("rstmid_rx",   {24'h0, rx8}, 32'h0);
        check("rstmid_rdy",  {31'h0, rdy8}, 32'h1);
        check("rstmid_miso", {31'h0, miso8}, 32'h0);
        begin
            int rxv0;
            rxv0 = n_rxv;
            for (int e = 0; e < 8; e++) begin
                repeat (HALF) @(negedge clk);
                sck  = ~sck;
                mosi = 1'($urandom_range(0, 1));
            end
            repeat (2 * HALF) @(negedge clk);
            check("rstmid_norxv", n_rxv - rxv0, 32'd0);
            check("rstmid_idle",  {31'h0, busy8}, 32'h0);
        end
        clear_fr();
        fr_mosi[0] = 32'h55;
        spi_frame("after_rst", 8, 1'b0, 1'b0, 1'b0, 1, 1'b0, 32'h0, 0, 1'b0);

        // Randomised frames on the 8-bit instance
        for (int f = 0; f < 8; f++) begin
            clear_fr();
            nw = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                fr_mosi[k] = $urandom_range(0, 255);
                fr_wr[k]   = 1'($urandom_range(0, 1));
                fr_wrw[k]  = $urandom_range(0, 255);
            end
            spi_frame("rand", 8, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      nw, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
